// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the dcache memory responder: FSM encoding and default
// geometry constants that must match the dcache side.
package dcache_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_BLOCK_BITS = 128;
  localparam int DEF_ADDR_BITS  = 28;
  localparam int DEF_IDX_BITS   = 6;
  localparam int DEF_LATENCY    = 5;

endpackage

// File: rtl/dcache_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after i_rr_ptr,
// wrapping modulo NUM_PORTS.
module dcache_mem_responder_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_BITS  = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_BITS-1:0]  i_rr_ptr,
  output logic [PTR_BITS-1:0]  o_grant,
  output logic                 o_any_req
);

  logic [NUM_PORTS-1:0] w_rot;
  logic [PTR_BITS-1:0]  w_offset;
  logic [PTR_BITS:0]    w_sum;

  // Rotate so that bit 0 is the port rr_ptr points at; lowest set bit wins.
  assign w_rot = NUM_PORTS'({i_req, i_req} >> i_rr_ptr);

  always_comb begin
    w_offset = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_offset = PTR_BITS'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_rr_ptr} + {1'b0, w_offset};
    if (w_sum >= (PTR_BITS+1)'(NUM_PORTS)) begin
      w_sum = w_sum - (PTR_BITS+1)'(NUM_PORTS);
    end
  end

  assign o_grant   = w_sum[PTR_BITS-1:0];
  assign o_any_req = |i_req;

endmodule

// File: rtl/dcache_mem_responder.sv
// Shared block memory serving refills and write-backs for several dcaches, one
// transaction at a time with round-robin fairness and fixed access latency.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int IDX_BITS   = DEF_IDX_BITS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             cache_mem_read,
  input  logic [NUM_PORTS-1:0]             cache_mem_write,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]   cache_mem_address,
  input  logic [NUM_PORTS*BLOCK_BITS-1:0]  cache_mem_writedata,
  output logic [BLOCK_BITS-1:0]            mem_readdata,
  output logic [NUM_PORTS-1:0]             mem_busywait
);

  localparam int PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_BITS = $clog2(LATENCY + 1);
  localparam int DEPTH    = 1 << IDX_BITS;

  state_t                r_state;
  logic [PTR_BITS-1:0]   r_grant;
  logic [PTR_BITS-1:0]   r_rr_ptr;
  logic [CNT_BITS-1:0]   r_count;
  logic                  r_write;
  logic [IDX_BITS-1:0]   r_index;
  logic [BLOCK_BITS-1:0] r_wdata;
  logic [BLOCK_BITS-1:0] r_mem [0:DEPTH-1];

  logic [NUM_PORTS-1:0]  w_req;
  logic [PTR_BITS-1:0]   w_grant;
  logic                  w_any_req;
  logic [ADDR_BITS-1:0]  w_sel_addr;
  logic [BLOCK_BITS-1:0] w_sel_wdata;
  logic                  w_sel_write;
  logic [NUM_PORTS-1:0]  w_done_mask;
  logic [PTR_BITS-1:0]   w_next_ptr;
  logic                  w_mem_we;
  logic                  w_unused_addr;

  assign w_req = cache_mem_read | cache_mem_write;

  dcache_mem_responder_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_BITS  (PTR_BITS)
  ) u_arb (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_grant),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant == PTR_BITS'(p)) begin
        w_sel_addr  = cache_mem_address[p*ADDR_BITS +: ADDR_BITS];
        w_sel_wdata = cache_mem_writedata[p*BLOCK_BITS +: BLOCK_BITS];
        w_sel_write = cache_mem_write[p];
      end
    end
  end

  // Upper address bits are deliberately dropped: blocks alias modulo DEPTH.
  assign w_unused_addr = ^w_sel_addr[ADDR_BITS-1:IDX_BITS];

  assign w_done_mask  = (r_state == ST_DONE) ? (NUM_PORTS'(1) << r_grant) : '0;
  assign mem_busywait = w_req & ~w_done_mask;

  assign w_next_ptr = (r_grant == PTR_BITS'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
  assign w_mem_we   = (r_state == ST_ACCESS) && (r_count == '0) && r_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_count      <= '0;
      r_write      <= 1'b0;
      r_index      <= '0;
      r_wdata      <= '0;
      mem_readdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_grant;
            r_write <= w_sel_write;
            r_index <= w_sel_addr[IDX_BITS-1:0];
            r_wdata <= w_sel_wdata;
            r_count <= CNT_BITS'(LATENCY - 1);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_state <= ST_DONE;
            if (!r_write) begin
              mem_readdata <= r_mem[r_index];
            end
          end
        end
        ST_DONE: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage is not reset; an aborted write never reaches the commit edge.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[r_index] <= r_wdata;
    end
  end

endmodule
